// File: rtl/sccb_config.sv
// SCCB (OV-camera style) register loader: walks a {reg_addr, value} table and issues
// 3-phase write transactions, honouring FFF0 delay entries and an FFFF terminator.
module sccb_config #(
    parameter int unsigned QUARTER      = 163,
    parameter logic [7:0]  DEVICE_ADDR  = 8'h42,
    parameter int unsigned DELAY_CYCLES = 650000
) (
    input  logic        system_clock_in,
    input  logic        system_reset,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sioc,
    output logic        siod_out,
    output logic        siod_oe,
    output logic        busy,
    output logic        done,
    output logic [7:0]  write_count
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StStart, StBit, StStop, StGap, StDelay, StFin
    } state_e;

    localparam int unsigned DelayW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [DelayW-1:0] DelayLast = DelayW'(DELAY_CYCLES - 1);
    localparam logic [9:0] TickLast = 10'(QUARTER - 1);

    state_e state_q, state_d;
    logic [9:0] tick_q, tick_d;
    logic [1:0] qtr_q, qtr_d;
    logic [4:0] bit_q, bit_d;
    logic fetch_wait_q, fetch_wait_d;
    logic [15:0] entry_q, entry_d;
    logic [DelayW-1:0] delay_q, delay_d;
    logic [7:0] rom_addr_q, rom_addr_d;
    logic [7:0] write_count_q, write_count_d;
    logic busy_q, busy_d, done_q, done_d;
    logic sioc_q, sioc_d, siod_out_q, siod_out_d, siod_oe_q, siod_oe_d;

    logic wrap, timed, next_entry, dont_care;
    logic [26:0] frame;
    logic [4:0] idx;

    always_ff @(posedge system_clock_in) begin
        if (system_reset) begin
            state_q       <= StIdle;
            tick_q        <= '0;
            qtr_q         <= '0;
            bit_q         <= '0;
            fetch_wait_q  <= 1'b0;
            entry_q       <= '0;
            delay_q       <= '0;
            rom_addr_q    <= '0;
            write_count_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            sioc_q        <= 1'b1;
            siod_out_q    <= 1'b1;
            siod_oe_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            qtr_q         <= qtr_d;
            bit_q         <= bit_d;
            fetch_wait_q  <= fetch_wait_d;
            entry_q       <= entry_d;
            delay_q       <= delay_d;
            rom_addr_q    <= rom_addr_d;
            write_count_q <= write_count_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            sioc_q        <= sioc_d;
            siod_out_q    <= siod_out_d;
            siod_oe_q     <= siod_oe_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tick_d        = tick_q;
        qtr_d         = qtr_q;
        bit_d         = bit_q;
        fetch_wait_d  = fetch_wait_q;
        entry_d       = entry_q;
        delay_d       = delay_q;
        rom_addr_d    = rom_addr_q;
        write_count_d = write_count_q;
        busy_d        = busy_q;
        done_d        = done_q;
        next_entry    = 1'b0;

        wrap  = (tick_q == TickLast);
        timed = (state_q == StStart) || (state_q == StBit) ||
                (state_q == StStop) || (state_q == StGap);
        if (timed) begin
            if (wrap) begin
                tick_d = '0;
                qtr_d  = qtr_q + 2'd1;
            end else begin
                tick_d = tick_q + 10'd1;
            end
        end else begin
            tick_d = '0;
            qtr_d  = '0;
        end

        unique case (state_q)
            StIdle, StFin: begin
                if (start) begin
                    state_d       = StFetch;
                    fetch_wait_d  = 1'b1;
                    rom_addr_d    = '0;
                    write_count_d = '0;
                    done_d        = 1'b0;
                    busy_d        = 1'b1;
                end
            end
            StFetch: begin
                // rom_data lags rom_addr by one cycle, so burn one cycle first
                if (fetch_wait_q) begin
                    fetch_wait_d = 1'b0;
                end else if (rom_data == 16'hFFFF) begin
                    state_d = StFin;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (rom_data == 16'hFFF0) begin
                    state_d = StDelay;
                    delay_d = '0;
                end else begin
                    entry_d = rom_data;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (wrap && qtr_q == 2'd1) begin
                    state_d = StBit;
                    qtr_d   = '0;
                    bit_d   = '0;
                end
            end
            StBit: begin
                if (wrap && qtr_q == 2'd3) begin
                    if (bit_q == 5'd26) state_d = StStop;
                    else bit_d = bit_q + 5'd1;
                end
            end
            StStop: begin
                if (wrap && qtr_q == 2'd3) begin
                    state_d = StGap;
                    if (write_count_q != 8'hFF) write_count_d = write_count_q + 8'd1;
                end
            end
            StGap: begin
                if (wrap && qtr_q == 2'd3) next_entry = 1'b1;
            end
            StDelay: begin
                if (delay_q == DelayLast) next_entry = 1'b1;
                else delay_d = delay_q + 1'b1;
            end
        endcase

        if (next_entry) begin
            if (rom_addr_q == 8'hFF) begin
                state_d = StFin;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                rom_addr_d   = rom_addr_q + 8'd1;
                state_d      = StFetch;
                fetch_wait_d = 1'b1;
            end
        end

        // Bus outputs decoded from next-state values so the registered pins track state_q
        frame     = {DEVICE_ADDR, 1'b1, entry_d[15:8], 1'b1, entry_d[7:0], 1'b1};
        idx       = 5'd26 - bit_d;
        dont_care = (idx == 5'd18) || (idx == 5'd9) || (idx == 5'd0);
        sioc_d     = 1'b1;
        siod_out_d = 1'b1;
        siod_oe_d  = 1'b0;
        unique case (state_d)
            StStart: begin
                siod_oe_d  = 1'b1;
                siod_out_d = 1'b0;
            end
            StBit: begin
                sioc_d     = qtr_d[1];
                siod_oe_d  = !dont_care;
                siod_out_d = dont_care ? 1'b1 : frame[idx];
            end
            StStop: begin
                sioc_d = qtr_d[1];
                if (qtr_d != 2'd3) begin
                    siod_oe_d  = 1'b1;
                    siod_out_d = 1'b0;
                end
            end
            StIdle, StFetch, StGap, StDelay, StFin: begin
            end
        endcase
    end

    assign rom_addr    = rom_addr_q;
    assign write_count = write_count_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sioc        = sioc_q;
    assign siod_out    = siod_out_q;
    assign siod_oe     = siod_oe_q;

endmodule
